// File: rtl/pll_reset_supervisor_if.sv
// pll_reset_supervisor_if: PLL control, lock status and system reset signals around the supervisor.
// The master side is the supervisor; the slave side is the PLL/SoC environment.
interface pll_reset_supervisor_if #(
    parameter int RW = 3
);
    logic          pll_locked;
    logic          soft_rst_req;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic          lock_fail;
    logic [RW-1:0] retry_count;

    modport master (
        input  pll_locked, soft_rst_req,
        output pll_rst, sys_rst, ready, lock_fail, retry_count
    );

    modport slave (
        output pll_locked, soft_rst_req,
        input  pll_rst, sys_rst, ready, lock_fail, retry_count
    );
endinterface

// File: rtl/pll_reset_supervisor.sv
// pll_reset_supervisor: pulses PLL reset, qualifies lock for a stable window, then releases sys_rst.
// Retries on lock timeout and latches lock_fail once every attempt has timed out.
module pll_reset_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 125000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int SYS_RST_HOLD_CYCLES = 256,
    parameter int MAX_RETRIES         = 4
) (
    input logic                    refclk,
    input logic                    rst,
    pll_reset_supervisor_if.master bus
);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int M0 = RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int M1 = M0 > LOCK_STABLE_CYCLES ? M0 : LOCK_STABLE_CYCLES;
    localparam int M2 = M1 > SYS_RST_HOLD_CYCLES ? M1 : SYS_RST_HOLD_CYCLES;
    localparam int CW = M2 > 1 ? $clog2(M2) : 1;

    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, HOLD, RUN, FAIL} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pll_rst_q, sys_rst_q, ready_q, lock_fail_q;
    logic                   locked_s;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            PLL_RST: state_d = cnt_q == CW'(RST_PULSE_CYCLES - 1) ? WAIT_LOCK : PLL_RST;
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    if (retry_q == RW'(MAX_RETRIES - 1)) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = PLL_RST;
                    end
                end
            end
            STABLE: state_d = !locked_s ? WAIT_LOCK : cnt_q == CW'(LOCK_STABLE_CYCLES - 1) ? HOLD : STABLE;
            HOLD:   state_d = !locked_s ? WAIT_LOCK : cnt_q == CW'(SYS_RST_HOLD_CYCLES - 1) ? RUN : HOLD;
            RUN: begin
                // Loss of lock outranks a soft request and starts a fresh retry budget.
                if (!locked_s) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end else if (bus.soft_rst_req) begin
                    state_d = HOLD;
                end
            end
            default: state_d = FAIL;
        endcase
        cnt_d = (state_d != state_q || state_q == RUN || state_q == FAIL) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
            pll_rst_q   <= state_d == PLL_RST;
            sys_rst_q   <= state_d != RUN;
            ready_q     <= state_d == RUN;
            lock_fail_q <= state_d == FAIL;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.ready       = ready_q;
    assign bus.lock_fail   = lock_fail_q;
    assign bus.retry_count = retry_q;
endmodule
